// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the count sequencer.
package count_seq_pkg;

  // Sequencer operating states; IDLE is the reset state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Encoding of the up_dn level input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/count_sequencer_if.sv
// Pulse/control inputs and count outputs of the sequencer, bundled as one bus.
interface count_seq_if #(
  parameter int WIDTH = 4
);
  logic             start_stop_p;
  logic             step_p;
  logic             clear_p;
  logic             load_p;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic             wrap_en;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             tc;

  // Side that produces the button pulses and switch levels.
  modport master (
    output start_stop_p, step_p, clear_p, load_p, load_val, up_dn, wrap_en,
    input  count, running, tc
  );

  // Side implemented by the sequencer itself.
  modport slave (
    input  start_stop_p, step_p, clear_p, load_p, load_val, up_dn, wrap_en,
    output count, running, tc
  );
endinterface

// File: rtl/count_sequencer_prescaler.sv
// Free-running tick generator: one-cycle pulse every TICK_DIV cycles while en=1.
module prescaler_tick #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_a_n,
  input  logic en,
  output logic tick
);
  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CW'(TICK_DIV - 1));

  // Count while enabled, restart after each tick, hold at zero when disabled.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      cnt_reg <= '0;
    end else if (!en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end
endmodule

// File: rtl/count_sequencer.sv
// Count register and run/pause/step/clear/load sequencing for the event counter.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 2**WIDTH - 1,
  parameter int TICK_DIV  = 50_000_000
) (
  input logic       clk,
  input logic       rst_a_n,
  count_seq_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             running_reg, running_next;
  logic             tc_reg, tc_next;
  logic             tick;
  logic             tick_en;
  logic             up;
  logic             do_step;
  logic [WIDTH-1:0] term_val, wrap_val, step_val;

  // The prescaler only runs while we stay in RUN; any pulse that can leave
  // RUN clears it in the same edge, and entries start from zero because it
  // was held disabled outside RUN.
  assign tick_en = (state_reg == RUN) && !bus.clear_p && !bus.load_p && !bus.start_stop_p;

  prescaler_tick #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .rst_a_n (rst_a_n),
    .en      (tick_en),
    .tick    (tick)
  );

  assign up       = (bus.up_dn == DIR_UP);
  assign term_val = up ? MAX_V : '0;
  assign wrap_val = up ? '0 : MAX_V;
  assign step_val = up ? count_reg + 1'b1 : count_reg - 1'b1;

  assign bus.count   = count_reg;
  assign bus.running = running_reg;
  assign bus.tc      = tc_reg;

  // Next-state, next-count and terminal pulse; only the highest-priority event acts.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    tc_next    = 1'b0;
    do_step    = 1'b0;

    if (bus.clear_p) begin
      state_next = IDLE;
      count_next = '0;
    end else if (bus.load_p) begin
      state_next = PAUSE;
      count_next = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start_stop_p) begin
            state_next = RUN;
          end else if (bus.step_p) begin
            state_next = PAUSE;
            do_step    = 1'b1;
          end
        end
        RUN: begin
          if (bus.start_stop_p) state_next = PAUSE;
          else if (tick)        do_step    = 1'b1;
        end
        PAUSE: begin
          if (bus.start_stop_p) state_next = RUN;
          else if (bus.step_p)  do_step    = 1'b1;
        end
        DONE: begin
          // Restart only when the direction leads away from the held terminal.
          if (bus.start_stop_p &&
              (((count_reg == '0) && up) || ((count_reg == MAX_V) && !up))) begin
            state_next = RUN;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (do_step) begin
      if (count_reg == term_val) begin
        if (bus.wrap_en) count_next = wrap_val;
        else             state_next = DONE;
      end else begin
        count_next = step_val;
        if (step_val == term_val) begin
          tc_next = 1'b1;
          if (!bus.wrap_en) state_next = DONE;
        end
      end
    end
  end

  assign running_next = (state_next == RUN);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      running_reg <= 1'b0;
      tc_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      running_reg <= running_next;
      tc_reg      <= tc_next;
    end
  end
endmodule
